// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch: owns PC and IR, issues memory reads and holds the fetched word.
// Optional NUM_INST_EN builds a retired-instruction counter; otherwise num_inst is tied to 0.
module instr_fetch_unit #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] PC_RESET  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fetch_start,
  input  logic                 pc_write,
  input  logic [WORD_SIZE-1:0] pc_next,
  input  logic                 inputReady,
  input  logic [WORD_SIZE-1:0] data,
  output logic                 readM,
  output logic [WORD_SIZE-1:0] address,
  output logic [WORD_SIZE-1:0] ir_out,
  output logic [WORD_SIZE-1:0] pc_out,
  output logic [WORD_SIZE-1:0] pc_plus1,
  output logic                 instr_valid,
  output logic                 busy,
  input  logic                 inst_retire,
  output logic [WORD_SIZE-1:0] num_inst
);

  typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;

  state_t               state;
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] ir;
  logic [WORD_SIZE-1:0] fetch_pc;

  // a PC update in the same cycle as the fetch request redirects that fetch
  assign fetch_pc = pc_write ? pc_next : pc;
  assign pc_out   = pc;
  assign pc_plus1 = pc + WORD_SIZE'(1);
  assign ir_out   = ir;
  assign busy     = (state == REQ);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= PC_RESET;
      ir          <= '0;
      readM       <= 1'b0;
      address     <= '0;
      instr_valid <= 1'b0;
    end else begin
      if (pc_write) pc <= pc_next;
      case (state)
        IDLE: if (fetch_start) begin
          state   <= REQ;
          readM   <= 1'b1;
          address <= fetch_pc;
        end
        // address is frozen here so an in-flight fetch completes at its original PC
        REQ: if (inputReady) begin
          state       <= VALID;
          ir          <= data;
          readM       <= 1'b0;
          instr_valid <= 1'b1;
        end
        VALID: if (fetch_start) begin
          state       <= REQ;
          instr_valid <= 1'b0;
          readM       <= 1'b1;
          address     <= fetch_pc;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NUM_INST_EN
  logic [WORD_SIZE-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         cnt <= '0;
    else if (inst_retire) cnt <= cnt + WORD_SIZE'(1);
  end
  assign num_inst = cnt;
`else
  logic unused_retire;
  assign unused_retire = inst_retire;
  assign num_inst      = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded random + directed bench for instr_fetch_unit against a transaction-level fetch model.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        fetch_start = 1'b0, pc_write = 1'b0, inputReady = 1'b0, inst_retire = 1'b0;
  logic [15:0] pc_next = '0, data = '0;
  logic        readM, instr_valid, busy;
  logic [15:0] address, ir_out, pc_out, pc_plus1, num_inst;

  instr_fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .fetch_start(fetch_start), .pc_write(pc_write),
    .pc_next(pc_next), .inputReady(inputReady), .data(data), .readM(readM),
    .address(address), .ir_out(ir_out), .pc_out(pc_out), .pc_plus1(pc_plus1),
    .instr_valid(instr_valid), .busy(busy), .inst_retire(inst_retire), .num_inst(num_inst)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: one outstanding fetch at most, IR holds last completed word
  logic [15:0] m_pc = '0, m_ir = '0, m_addr = '0, m_cnt = '0;
  logic        m_inflight = 1'b0, m_iv = 1'b0;
  logic [15:0] addr_q[$];
  logic [15:0] ir_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_ir = '0; m_addr = '0; m_cnt = '0;
    m_inflight = 1'b0; m_iv = 1'b0;
    addr_q.delete(); ir_q.delete();
  endtask

  // apply inputs for the next rising edge and advance the model to post-edge state
  task automatic drive(input logic fs, input logic pw, input logic [15:0] pn,
                       input logic rdy, input logic [15:0] d, input logic ret);
    logic [15:0] fpc;
    @(negedge clk); #1;
    fetch_start = fs; pc_write = pw; pc_next = pn; inputReady = rdy; data = d; inst_retire = ret;
    fpc = pw ? pn : m_pc;
    if (pw) m_pc = pn;
    if (!m_inflight && fs) begin
      m_inflight = 1'b1; m_iv = 1'b0; m_addr = fpc;
      addr_q.push_back(fpc);
    end else if (m_inflight && rdy) begin
      m_inflight = 1'b0; m_iv = 1'b1; m_ir = d;
      ir_q.push_back(d);
    end
`ifdef NUM_INST_EN
    if (ret) m_cnt = m_cnt + 16'd1;
`endif
  endtask

  task automatic do_reset(input bit check_now);
    @(negedge clk); #1;
    fetch_start = 0; pc_write = 0; inputReady = 0; inst_retire = 0;
    reset_n = 1'b0;
    #1;
    if (check_now) begin
      chk("reset_readM_immediate", {15'b0, readM}, 16'h0000);
      chk("reset_pc_immediate", pc_out, 16'h0000);
      chk("reset_ir_immediate", ir_out, 16'h0000);
    end
    model_reset();
    @(negedge clk); #2;
    reset_n = 1'b1;
  endtask

  // monitor: per-cycle observation plus queue pops on new request / new valid word
  logic prev_rd = 1'b0, prev_iv = 1'b0;
  always @(negedge clk) begin
    logic [15:0] e;
    if (readM && !prev_rd) begin
      if (addr_q.size() == 0) chk("unexpected_request", address, 16'hxxxx);
      else begin e = addr_q.pop_front(); chk("req_address", address, e); end
    end
    if (instr_valid && !prev_iv) begin
      if (ir_q.size() == 0) chk("unexpected_valid", ir_out, 16'hxxxx);
      else begin e = ir_q.pop_front(); chk("fetched_ir", ir_out, e); end
    end
    prev_rd = readM;
    prev_iv = instr_valid;
    chk("readM", {15'b0, readM}, {15'b0, m_inflight});
    chk("busy", {15'b0, busy}, {15'b0, m_inflight});
    chk("instr_valid", {15'b0, instr_valid}, {15'b0, m_iv});
    chk("address", address, m_addr);
    chk("ir_out", ir_out, m_ir);
    chk("pc_out", pc_out, m_pc);
    chk("pc_plus1", pc_plus1, m_pc + 16'd1);
    chk("num_inst", num_inst, m_cnt);
  end

  initial begin
    #1 reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;

    // first fetch, memory answers two cycles after the request
    drive(1, 0, 16'h0, 0, 16'h0, 0);
    drive(0, 0, 16'h0, 0, 16'h0, 0);
    drive(0, 0, 16'h0, 1, 16'h9123, 0);
    drive(0, 0, 16'h0, 0, 16'h0, 0);
    chk("first_ir", ir_out, 16'h9123);

    // redirected fetch from VALID
    drive(1, 1, 16'h0040, 0, 16'h0, 0);
    drive(0, 0, 16'h0, 0, 16'h0, 0);
    chk("redirect_address", address, 16'h0040);
    chk("redirect_iv_low", {15'b0, instr_valid}, 16'h0000);
    drive(0, 0, 16'h0, 1, 16'hA0A0, 0);

    // pc_write during REQ must not move the in-flight address
    drive(1, 1, 16'h0005, 0, 16'h0, 0);
    drive(0, 1, 16'h0100, 0, 16'h0, 0);
    drive(0, 0, 16'h0, 1, 16'h5555, 0);
    drive(0, 0, 16'h0, 0, 16'h0, 0);
    chk("req_addr_held", address, 16'h0005);
    chk("req_ir_old_addr", ir_out, 16'h5555);
    chk("pc_after_req_write", pc_out, 16'h0100);

    // abort mid-REQ, then stray inputReady in IDLE
    drive(1, 0, 16'h0, 0, 16'h0, 0);
    drive(0, 0, 16'h0, 0, 16'h0, 0);
    do_reset(1'b1);
    drive(0, 0, 16'h0, 1, 16'hBEEF, 0);
    drive(0, 0, 16'h0, 0, 16'h0, 0);
    chk("idle_ready_ignored", ir_out, 16'h0000);

    // PC wrap and retire counter
    drive(0, 1, 16'hFFFF, 0, 16'h0, 1);
    drive(0, 0, 16'h0, 0, 16'h0, 1);
    drive(0, 0, 16'h0, 0, 16'h0, 1);
    drive(0, 0, 16'h0, 0, 16'h0, 0);
    chk("pc_plus1_wrap", pc_plus1, 16'h0000);
`ifdef NUM_INST_EN
    chk("num_inst_3", num_inst, 16'd3);
`else
    chk("num_inst_off", num_inst, 16'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, 16'($urandom),
            $urandom_range(0, 9) < 4, 16'($urandom), $urandom_range(0, 1) == 1);
      if ((i % 250) == 249) do_reset(1'b0);
    end
    drive(0, 0, 16'h0, 0, 16'h0, 0);
    drive(0, 0, 16'h0, 0, 16'h0, 0);
    chk("addr_q_drained", 16'(addr_q.size()), 16'd0);
    chk("ir_q_drained", 16'(ir_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
